// File: rtl/msrv32_pkg.sv
// Shared types and constants for the msrv32 program-counter slice.
// Holds the PC-unit FSM state encoding, the default boot vector and the
// next-PC source encoding used by the select logic.
package msrv32_pkg;

    // Default first fetch address after reset.
    localparam logic [31:0] BootAddressDefault = 32'h0000_0000;

    // PC-unit control states.
    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } pc_state_e;

    // Next-PC source, ordered from highest to lowest priority.
    typedef enum logic [1:0] {
        SrcTrap   = 2'd0,
        SrcMret   = 2'd1,
        SrcBranch = 2'd2,
        SrcSeq    = 2'd3
    } pc_src_e;

    // Any non-sequential source changes the instruction stream.
    function automatic logic is_redirect(pc_src_e src);
        return src != SrcSeq;
    endfunction

endpackage

// File: rtl/msrv32_pc_unit_if.sv
// Bus bundle between the core control units and the PC unit.
// The master side drives redirect requests and fetch-bus ready; the slave
// side (the PC unit) returns the PC, link value, fetch address and flags.
interface msrv32_pc_unit_if;

    logic        ahb_ready_in;
    logic        branch_taken_in;
    logic [31:0] iadder_in;
    logic        trap_taken_in;
    logic [31:0] trap_address_in;
    logic        mret_in;
    logic [31:0] epc_in;

    logic [31:0] pc_out;
    logic [31:0] pc_plus_4_out;
    logic [31:0] i_addr_out;
    logic        misaligned_instr_out;
    logic        flush_out;

    modport master (
        output ahb_ready_in,
        output branch_taken_in,
        output iadder_in,
        output trap_taken_in,
        output trap_address_in,
        output mret_in,
        output epc_in,
        input  pc_out,
        input  pc_plus_4_out,
        input  i_addr_out,
        input  misaligned_instr_out,
        input  flush_out
    );

    modport slave (
        input  ahb_ready_in,
        input  branch_taken_in,
        input  iadder_in,
        input  trap_taken_in,
        input  trap_address_in,
        input  mret_in,
        input  epc_in,
        output pc_out,
        output pc_plus_4_out,
        output i_addr_out,
        output misaligned_instr_out,
        output flush_out
    );

endinterface

// File: rtl/msrv32_next_pc_mux.sv
// Combinational next-PC priority select with misaligned-target detection.
// Priority: trap, mret, aligned taken branch, sequential.
// Optional macro MSRV32_COMPRESSED_EN relaxes targets to 2-byte alignment
// and disables misaligned detection.
module msrv32_next_pc_mux
    import msrv32_pkg::*;
(
    input  logic [31:0] pc_in,
    input  logic [31:0] pc_plus_4_in,
    input  logic        branch_taken_in,
    input  logic [31:0] iadder_in,
    input  logic        trap_taken_in,
    input  logic [31:0] trap_address_in,
    input  logic        mret_in,
    input  logic [31:0] epc_in,
    output pc_src_e     src_out,
    output logic [31:0] next_pc_out,
    output logic        misaligned_out
);

    logic [31:0] branch_target;
    logic        target_misaligned;
    logic        unused_iadder_b0;

    // Bit 0 is always cleared on jump targets (JALR rule).
    assign branch_target    = {iadder_in[31:1], 1'b0};
    assign unused_iadder_b0 = iadder_in[0];

`ifdef MSRV32_COMPRESSED_EN
    assign target_misaligned = 1'b0;
`else
    assign target_misaligned = iadder_in[1];
`endif

    // Priority select; a misaligned branch holds the PC for the trap unit.
    always_comb begin
        src_out        = SrcSeq;
        next_pc_out    = pc_plus_4_in;
        misaligned_out = 1'b0;
        if (trap_taken_in) begin
            src_out     = SrcTrap;
            next_pc_out = trap_address_in;
        end else if (mret_in) begin
            src_out     = SrcMret;
            next_pc_out = epc_in;
        end else if (branch_taken_in) begin
            if (target_misaligned) begin
                misaligned_out = 1'b1;
                next_pc_out    = pc_in;
            end else begin
                src_out     = SrcBranch;
                next_pc_out = branch_target;
            end
        end
    end

endmodule

// File: rtl/msrv32_pc_unit.sv
// Program-counter unit: owns the architectural PC, selects the next fetch
// address, flags misaligned jump/branch targets and raises a one-cycle
// fetch flush after every redirect. Fetch-bus stalls freeze all state.
// Optional macro MSRV32_COMPRESSED_EN enables 2-byte target alignment.
module msrv32_pc_unit
    import msrv32_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = BootAddressDefault
) (
    input  logic ms_riscv32_mp_clk_in,
    input  logic ms_riscv32_mp_rst_in,
    msrv32_pc_unit_if.slave bus
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        misaligned_q, misaligned_d;

    logic [31:0] pc_plus_4;
    logic [31:0] mux_next_pc;
    logic        mux_misaligned;
    pc_src_e     mux_src;
    logic [31:0] i_addr;

    // Modulo-2^32 increment; wrap from 32'hFFFF_FFFC to 0 is intended.
    assign pc_plus_4 = pc_q + 32'd4;

    msrv32_next_pc_mux u_next_pc_mux (
        .pc_in           (pc_q),
        .pc_plus_4_in    (pc_plus_4),
        .branch_taken_in (bus.branch_taken_in),
        .iadder_in       (bus.iadder_in),
        .trap_taken_in   (bus.trap_taken_in),
        .trap_address_in (bus.trap_address_in),
        .mret_in         (bus.mret_in),
        .epc_in          (bus.epc_in),
        .src_out         (mux_src),
        .next_pc_out     (mux_next_pc),
        .misaligned_out  (mux_misaligned)
    );

    // Next-state, next-PC and fetch address; applied only on accepted cycles.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        misaligned_d = misaligned_q;
        i_addr       = mux_next_pc;
        unique case (state_q)
            StBoot: begin
                i_addr       = BOOT_ADDRESS;
                pc_d         = BOOT_ADDRESS;
                misaligned_d = 1'b0;
                state_d      = StRun;
            end
            StRun, StFlush: begin
                pc_d         = mux_next_pc;
                misaligned_d = mux_misaligned;
                state_d      = is_redirect(mux_src) ? StFlush : StRun;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    // State registers; reset beats stall, stall freezes everything else.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (ms_riscv32_mp_rst_in) begin
            state_q      <= StBoot;
            pc_q         <= BOOT_ADDRESS - 32'd4;
            misaligned_q <= 1'b0;
        end else if (bus.ahb_ready_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign bus.pc_out               = pc_q;
    assign bus.pc_plus_4_out        = pc_plus_4;
    assign bus.i_addr_out           = i_addr;
    assign bus.misaligned_instr_out = misaligned_q;
    assign bus.flush_out            = (state_q == StFlush);

endmodule

// File: tb/tb_msrv32_pc_unit.sv
// Directed self-checking bench for msrv32_pc_unit (BOOT_ADDRESS = 32'h1000).
module tb_msrv32_pc_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    msrv32_pc_unit_if bus ();

    msrv32_pc_unit #(
        .BOOT_ADDRESS (32'h0000_1000)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .bus                  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] pc, input logic fl,
                               input logic mis);
        check({tag, " pc"}, bus.pc_out, pc);
        check({tag, " flush"}, {31'd0, bus.flush_out}, {31'd0, fl});
        check({tag, " misaligned"}, {31'd0, bus.misaligned_instr_out}, {31'd0, mis});
    endtask

    task automatic idle_inputs();
        bus.branch_taken_in = 1'b0;
        bus.iadder_in       = 32'd0;
        bus.trap_taken_in   = 1'b0;
        bus.trap_address_in = 32'd0;
        bus.mret_in         = 1'b0;
        bus.epc_in          = 32'd0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.ahb_ready_in = 1'b0;
        idle_inputs();

        // Reset held two cycles.
        tick();
        tick();
        check_state("reset", 32'h0000_0FFC, 1'b0, 1'b0);
        check("reset pc+4", bus.pc_plus_4_out, 32'h0000_1000);
        check("reset iaddr", bus.i_addr_out, 32'h0000_1000);

        // Boot then sequential fetch.
        rst = 1'b0;
        bus.ahb_ready_in = 1'b1;
        #1;
        check("boot iaddr", bus.i_addr_out, 32'h0000_1000);
        tick();
        check_state("boot", 32'h0000_1000, 1'b0, 1'b0);
        tick();
        check("seq1 pc", bus.pc_out, 32'h0000_1004);
        tick();
        check("seq2 pc", bus.pc_out, 32'h0000_1008);

        // Jump to 0x2000, then from FLUSH take 0x2041 (bit 0 cleared).
        bus.branch_taken_in = 1'b1;
        bus.iadder_in       = 32'h0000_2000;
        #1;
        check("br iaddr", bus.i_addr_out, 32'h0000_2000);
        tick();
        check_state("br2000", 32'h0000_2000, 1'b1, 1'b0);
        bus.iadder_in = 32'h0000_2041;
        #1;
        check("br2041 iaddr", bus.i_addr_out, 32'h0000_2040);
        tick();
        check_state("br2041", 32'h0000_2040, 1'b1, 1'b0);
        idle_inputs();
        tick();
        check_state("after br2041", 32'h0000_2044, 1'b0, 1'b0);

        // Back to 0x2000, then a target with bit 1 set.
        bus.branch_taken_in = 1'b1;
        bus.iadder_in       = 32'h0000_2000;
        tick();
        check_state("br2000 again", 32'h0000_2000, 1'b1, 1'b0);
        bus.iadder_in = 32'h0000_2042;
        tick();
`ifdef MSRV32_COMPRESSED_EN
        check_state("br2042", 32'h0000_2042, 1'b1, 1'b0);
        idle_inputs();
        tick();
        check_state("after br2042", 32'h0000_2046, 1'b0, 1'b0);
`else
        check_state("br2042", 32'h0000_2000, 1'b0, 1'b1);
        idle_inputs();
        tick();
        check_state("after br2042", 32'h0000_2004, 1'b0, 1'b0);
`endif

        // Trap + mret + misaligned branch: trap wins, no flag.
        bus.trap_taken_in   = 1'b1;
        bus.mret_in         = 1'b1;
        bus.branch_taken_in = 1'b1;
        bus.trap_address_in = 32'h0000_0100;
        bus.epc_in          = 32'h0000_0500;
        bus.iadder_in       = 32'h0000_3002;
        #1;
        check("trap iaddr", bus.i_addr_out, 32'h0000_0100);
        tick();
        check_state("trap", 32'h0000_0100, 1'b1, 1'b0);
        idle_inputs();

        // Stall three cycles in FLUSH.
        bus.ahb_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_state("stall", 32'h0000_0100, 1'b1, 1'b0);
        end
        check("stall iaddr", bus.i_addr_out, 32'h0000_0104);
        bus.ahb_ready_in = 1'b1;
        tick();
        check_state("unstall", 32'h0000_0104, 1'b0, 1'b0);

        // mret alone.
        bus.mret_in = 1'b1;
        bus.epc_in  = 32'h0000_0600;
        tick();
        check_state("mret", 32'h0000_0600, 1'b1, 1'b0);
        idle_inputs();

        // Wrap at top of address space.
        bus.branch_taken_in = 1'b1;
        bus.iadder_in       = 32'hFFFF_FFFC;
        tick();
        check_state("br top", 32'hFFFF_FFFC, 1'b1, 1'b0);
        check("top pc+4", bus.pc_plus_4_out, 32'h0000_0000);
        idle_inputs();
        tick();
        check_state("wrap", 32'h0000_0000, 1'b0, 1'b0);

        // Reset mid-FLUSH, with a stall pending.
        bus.branch_taken_in = 1'b1;
        bus.iadder_in       = 32'h0000_0040;
        tick();
        check_state("br40", 32'h0000_0040, 1'b1, 1'b0);
        idle_inputs();
        rst = 1'b1;
        bus.ahb_ready_in = 1'b0;
        tick();
        check_state("mid reset", 32'h0000_0FFC, 1'b0, 1'b0);
        check("mid reset iaddr", bus.i_addr_out, 32'h0000_1000);
        rst = 1'b0;
        bus.ahb_ready_in = 1'b1;
        tick();
        check_state("reboot", 32'h0000_1000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
